// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit positions, hex glyph patterns,
// capture FSM states and small select-decoding helpers.
package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] SEG_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG_HEX_1 = 7'h06;
    localparam logic [6:0] SEG_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG_HEX_4 = 7'h66;
    localparam logic [6:0] SEG_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG_HEX_7 = 7'h07;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;
    localparam logic [6:0] SEG_HEX_C = 7'h39;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;
    localparam logic [6:0] SEG_HEX_E = 7'h79;
    localparam logic [6:0] SEG_HEX_F = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        TRACK   = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] onehot4_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern decoder: maps segments a..g back to a
// hex value, flagging all-off and unrecognised patterns.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [SEG_G:SEG_A] seg,
    output logic               known,
    output logic               is_blank,
    output logic [3:0]         value
);

    // Glyph lookup; anything outside the hex table is reported as unknown
    always_comb begin
        known    = 1'b1;
        is_blank = 1'b0;
        value    = 4'h0;
        case (seg)
            SEG_HEX_0: value = 4'h0;
            SEG_HEX_1: value = 4'h1;
            SEG_HEX_2: value = 4'h2;
            SEG_HEX_3: value = 4'h3;
            SEG_HEX_4: value = 4'h4;
            SEG_HEX_5: value = 4'h5;
            SEG_HEX_6: value = 4'h6;
            SEG_HEX_7: value = 4'h7;
            SEG_HEX_8: value = 4'h8;
            SEG_HEX_9: value = 4'h9;
            SEG_HEX_A: value = 4'hA;
            SEG_HEX_B: value = 4'hB;
            SEG_HEX_C: value = 4'hC;
            SEG_HEX_D: value = 4'hD;
            SEG_HEX_E: value = 4'hE;
            SEG_HEX_F: value = 4'hF;
            SEG_BLANK: begin
                known    = 1'b0;
                is_blank = 1'b1;
            end
            default: begin
                known    = 1'b0;
                is_blank = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg_mux_decoder.sv
// Receive-side decoder for a 4-digit multiplexed seven-segment bus: qualifies
// each select window for stability and reconstructs the displayed digits.
module seg_mux_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter bit INVERT        = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sel,
    input  logic [7:0] seg,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] dp,
    output logic [3:0] valid,
    output logic [3:0] blank,
    output logic       frame_done,
    output logic       err
);

    localparam int               CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [11:0]      raw_s;
    logic [11:0]      in_q_r;
    logic             same_s;
    logic [CNT_W-1:0] cnt_r;
    state_t           state_r;
    state_t           state_nxt_s;

    logic             capture_s;
    logic             take_s;
    logic             illegal_s;
    logic [1:0]       idx_s;
    logic [3:0]       seen_set_s;

    logic [3:0]       sel_q_s;
    logic [7:0]       seg_q_s;
    logic             dec_known_s;
    logic             dec_blank_s;
    logic [3:0]       dec_value_s;

    logic [3:0]       digit_r [4];
    logic [3:0]       dp_r;
    logic [3:0]       valid_r;
    logic [3:0]       blank_r;
    logic [3:0]       seen_r;
    logic             frame_done_r;
    logic             err_r;

    // Optional pin-level inversion ahead of the input register
    always_comb begin
        if (INVERT) begin
            raw_s = ~{sel, seg};
        end else begin
            raw_s = {sel, seg};
        end
    end

    assign same_s  = (raw_s == in_q_r);
    assign sel_q_s = in_q_r[11:8];
    assign seg_q_s = in_q_r[7:0];

    // Input register and saturating stability counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_q_r <= 12'd0;
            cnt_r  <= '0;
        end else begin
            in_q_r <= raw_s;
            if (!same_s) begin
                cnt_r <= '0;
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= TRACK;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; a change seen while in CAPTURE must reopen tracking
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            TRACK: begin
                if (same_s && (cnt_r == CNT_MAX)) begin
                    state_nxt_s = CAPTURE;
                end else begin
                    state_nxt_s = TRACK;
                end
            end
            CAPTURE: begin
                if (!same_s) begin
                    state_nxt_s = TRACK;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            HOLD: begin
                if (!same_s) begin
                    state_nxt_s = TRACK;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = TRACK;
        endcase
    end

    // FSM outputs: the capture strobe fires on the edge that enters CAPTURE
    always_comb begin
        capture_s  = 1'b0;
        take_s     = 1'b0;
        illegal_s  = 1'b0;
        idx_s      = onehot4_index(sel_q_s);
        seen_set_s = seen_r | sel_q_s;
        if ((state_r == TRACK) && (state_nxt_s == CAPTURE)) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
        if (capture_s && is_onehot4(sel_q_s)) begin
            take_s = 1'b1;
        end else if (capture_s && (sel_q_s != 4'd0)) begin
            illegal_s = 1'b1;
        end else begin
            take_s    = 1'b0;
            illegal_s = 1'b0;
        end
    end

    seg7_decode u_decode (
        .seg      (seg_q_s[SEG_G:SEG_A]),
        .known    (dec_known_s),
        .is_blank (dec_blank_s),
        .value    (dec_value_s)
    );

    // Per-digit capture state, frame tracking and one-cycle pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                digit_r[i] <= 4'd0;
            end
            dp_r         <= 4'd0;
            valid_r      <= 4'd0;
            blank_r      <= 4'd0;
            seen_r       <= 4'd0;
            frame_done_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            err_r        <= 1'b0;
            if (take_s) begin
                dp_r[idx_s] <= seg_q_s[SEG_DP];
                if (dec_known_s) begin
                    digit_r[idx_s] <= dec_value_s;
                    valid_r[idx_s] <= 1'b1;
                    blank_r[idx_s] <= 1'b0;
                end else if (dec_blank_s) begin
                    valid_r[idx_s] <= 1'b0;
                    blank_r[idx_s] <= 1'b1;
                end else begin
                    valid_r[idx_s] <= 1'b0;
                    blank_r[idx_s] <= 1'b0;
                    err_r          <= 1'b1;
                end
                if (seen_set_s == 4'hF) begin
                    frame_done_r <= 1'b1;
                    seen_r       <= 4'd0;
                end else begin
                    seen_r <= seen_set_s;
                end
            end else if (illegal_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign digit0     = digit_r[0];
    assign digit1     = digit_r[1];
    assign digit2     = digit_r[2];
    assign digit3     = digit_r[3];
    assign dp         = dp_r;
    assign valid      = valid_r;
    assign blank      = blank_r;
    assign frame_done = frame_done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_seg_mux_decoder.sv
// Self-checking bench for seg_mux_decoder: directed scenarios plus random
// select/segment windows compared every cycle against a run-length model.
module tb_seg_mux_decoder;

    localparam int N = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] sel;
    logic [7:0] seg;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [3:0] dp, valid, blank;
    logic       frame_done, err;

    seg_mux_decoder #(.STABLE_CYCLES(N), .INVERT(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel        (sel),
        .seg        (seg),
        .digit0     (digit0),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .dp         (dp),
        .valid      (valid),
        .blank      (blank),
        .frame_done (frame_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int n_checks = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;
    int err_cnt  = 0;

    // reference model state
    logic [3:0]  m_digit [4];
    logic [3:0]  m_dp, m_valid, m_blank, m_seen;
    logic        m_fd, m_err;
    logic [11:0] m_last;
    int          m_run;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_digit[i] = 4'd0;
        m_dp = 4'd0; m_valid = 4'd0; m_blank = 4'd0; m_seen = 4'd0;
        m_fd = 1'b0; m_err = 1'b0;
        m_last = 12'd0;
        m_run  = 1;
    endtask

    task automatic model_capture(input logic [11:0] v);
        logic [3:0] s;
        logic [7:0] g;
        int         i;
        int         found;
        s = v[11:8];
        g = v[7:0];
        if ($countones(s) > 1) begin
            m_err = 1'b1;
        end else if ($countones(s) == 1) begin
            i = 0;
            for (int k = 0; k < 4; k++) if (s[k]) i = k;
            m_dp[i] = g[7];
            found = -1;
            for (int k = 0; k < 16; k++) if (hex_tab[k] == g[6:0]) found = k;
            if (found >= 0) begin
                m_digit[i] = 4'(found);
                m_valid[i] = 1'b1;
                m_blank[i] = 1'b0;
            end else if (g[6:0] == 7'd0) begin
                m_valid[i] = 1'b0;
                m_blank[i] = 1'b1;
            end else begin
                m_valid[i] = 1'b0;
                m_blank[i] = 1'b0;
                m_err      = 1'b1;
            end
            m_seen[i] = 1'b1;
            if (m_seen == 4'hF) begin
                m_fd   = 1'b1;
                m_seen = 4'd0;
            end
        end
    endtask

    // A window is taken on the edge where its value has been present N+1 edges.
    task automatic model_edge();
        logic [11:0] cur;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_fd  = 1'b0;
            m_err = 1'b0;
            cur   = {sel, seg};
            if (cur == m_last) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_last = cur;
                m_run  = 1;
            end
            if (m_run == N + 1) model_capture(cur);
        end
    endtask

    task automatic compare_all();
        check_eq("digit0", digit0, m_digit[0]);
        check_eq("digit1", digit1, m_digit[1]);
        check_eq("digit2", digit2, m_digit[2]);
        check_eq("digit3", digit3, m_digit[3]);
        check_eq("dp", dp, m_dp);
        check_eq("valid", valid, m_valid);
        check_eq("blank", blank, m_blank);
        check_eq("frame_done", frame_done, m_fd);
        check_eq("err", err, m_err);
        if (frame_done === 1'b1) fd_cnt++;
        if (err === 1'b1) err_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic [3:0] s, input logic [7:0] g, input int n);
        sel = s;
        seg = g;
        repeat (n) step();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    int fd0, err0;
    logic [3:0] rs;
    logic [7:0] rg;

    initial begin
        rst_n = 1'b0;
        sel   = 4'd0;
        seg   = 8'd0;
        model_reset();
        do_reset(2);
        check_eq("reset_outputs", {digit3, digit2, digit1, digit0, dp, valid, blank, frame_done, err}, 30'd0);

        // single digit: capture lands on the fifth edge the value is present
        drive(4'b0001, 8'h06, 4);
        check_eq("single_before", valid[0], 1'b0);
        drive(4'b0001, 8'h06, 1);
        check_eq("single_digit0", digit0, 4'h1);
        check_eq("single_valid0", valid[0], 1'b1);
        drive(4'b0001, 8'h06, 5);

        // glitch shorter than the stability window
        fd0 = fd_cnt; err0 = err_cnt;
        drive(4'b0010, 8'h5B, 3);
        drive(4'b0000, 8'h00, 6);
        check_eq("glitch_digit1", digit1, 4'h0);
        check_eq("glitch_valid1", valid[1], 1'b0);
        check_eq("glitch_dp1", dp[1], 1'b0);
        check_eq("glitch_pulses", fd_cnt + err_cnt - fd0 - err0, 0);

        // two full frames from a clean start
        do_reset(1);
        fd0 = fd_cnt;
        for (int f = 0; f < 2; f++) begin
            drive(4'b1000, 8'h71, 8);
            drive(4'b0100, 8'h79, 8);
            drive(4'b0010, 8'h5E, 8);
            check_eq("frame_no_early_pulse", fd_cnt - fd0, f);
            drive(4'b0001, 8'h39, 8);
        end
        check_eq("frame_pulses", fd_cnt - fd0, 2);
        check_eq("frame_digits", {digit3, digit2, digit1, digit0}, 16'hFEDC);

        // decimal point then blank on digit 2
        drive(4'b0100, 8'hBF, 8);
        check_eq("dp_digit2", digit2, 4'h0);
        check_eq("dp_dp2", dp[2], 1'b1);
        drive(4'b0100, 8'h00, 8);
        check_eq("blank_blank2", blank[2], 1'b1);
        check_eq("blank_valid2", valid[2], 1'b0);
        check_eq("blank_digit2", digit2, 4'h0);

        // illegal select and illegal pattern
        err0 = err_cnt;
        drive(4'b0011, 8'h06, 8);
        check_eq("illegal_sel_err", err_cnt - err0, 1);
        check_eq("illegal_sel_digits", {digit1, digit0}, 8'hDC);
        drive(4'b1000, 8'h55, 8);
        check_eq("illegal_seg_err", err_cnt - err0, 2);
        check_eq("illegal_seg_valid3", valid[3], 1'b0);
        check_eq("illegal_seg_digit3", digit3, 4'hF);

        // reset after three of four digits, then one complete frame
        do_reset(1);
        drive(4'b0001, 8'h3F, 8);
        drive(4'b0010, 8'h06, 8);
        drive(4'b0100, 8'h5B, 8);
        do_reset(1);
        check_eq("midreset_outputs", {digit3, digit2, digit1, digit0, dp, valid, blank, frame_done, err}, 30'd0);
        fd0 = fd_cnt;
        drive(4'b0001, 8'h4F, 8);
        drive(4'b0010, 8'h66, 8);
        drive(4'b0100, 8'h6D, 8);
        drive(4'b1000, 8'h7D, 8);
        check_eq("midreset_frame", fd_cnt - fd0, 1);

        // random windows, including glitches, blanks, bad patterns and resets
        for (int w = 0; w < 400; w++) begin
            case ($urandom_range(0, 9))
                7:       rs = 4'd0;
                8, 9:    rs = 4'($urandom_range(0, 15));
                default: rs = 4'b0001 << $urandom_range(0, 3);
            endcase
            case ($urandom_range(0, 9))
                7:       rg = {1'($urandom_range(0, 1)), 7'h00};
                8, 9:    rg = 8'($urandom_range(0, 255));
                default: rg = {1'($urandom_range(0, 1)), hex_tab[$urandom_range(0, 15)]};
            endcase
            if ($urandom_range(0, 39) == 0) do_reset(1);
            drive(rs, rg, $urandom_range(1, 10));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
